// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage data-memory request/response bundle
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        stall;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        misalign_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        input  stall, resp_valid, resp_rdata, misalign_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        output stall, resp_valid, resp_rdata, misalign_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-accurate, size-aware data memory responder
// Optional feature macro: DMEM_POSTED_STORE_EN (aligned stores complete in IDLE without stalling)
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          write_q;
    logic [AW-1:0] idx_q;
    logic [2:0]    off_q;
    logic [63:0]   wdata_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          resp_valid_r;
    logic [63:0]   resp_rdata_r;
    logic          misalign_r;
    logic [63:0]   mem [DEPTH];

    logic [AW-1:0] idx_in;
    logic [2:0]    off_in;
    logic          posted;
    logic          unused_addr_bits;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            2'b10:   r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Read-modify-write of only the addressed little-endian lanes.
    function automatic logic [63:0] merge(input logic [63:0] word, input logic [63:0] wdata,
                                          input logic [1:0] size, input logic [2:0] off);
        logic [5:0]  sh;
        logic [63:0] m;
        sh = {off, 3'b000};
        m  = lane_mask(size) << sh;
        return (word & ~m) | ((wdata << sh) & m);
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] word, input logic [1:0] size,
                                            input logic [2:0] off, input logic uns);
        logic [5:0]  sh;
        logic [63:0] f;
        logic [63:0] r;
        sh = {off, 3'b000};
        f  = word >> sh;
        case (size)
            2'b00:   r = uns ? {56'd0, f[7:0]}  : {{56{f[7]}},  f[7:0]};
            2'b01:   r = uns ? {48'd0, f[15:0]} : {{48{f[15]}}, f[15:0]};
            2'b10:   r = uns ? {32'd0, f[31:0]} : {{32{f[31]}}, f[31:0]};
            default: r = f;
        endcase
        return r;
    endfunction

    always_comb begin
        idx_in = bus.req_addr[3 +: AW];
        off_in = bus.req_addr[2:0];
`ifdef DMEM_POSTED_STORE_EN
        posted = bus.req_write && !misaligned(bus.req_size, off_in);
`else
        posted = 1'b0;
`endif
    end

    // Upper address bits wrap away by design.
    assign unused_addr_bits = ^bus.req_addr[63:3+AW];

    assign bus.stall        = !reset && (((state == IDLE) && bus.req_valid && !posted) || (state == WAIT));
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_rdata   = resp_rdata_r;
    assign bus.misalign_err = misalign_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            off_q        <= 3'd0;
            wdata_q      <= 64'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 64'd0;
            misalign_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (posted) begin
                            mem[idx_in] <= merge(mem[idx_in], bus.req_wdata, bus.req_size, off_in);
                        end else begin
                            write_q <= bus.req_write;
                            idx_q   <= idx_in;
                            off_q   <= off_in;
                            wdata_q <= bus.req_wdata;
                            size_q  <= bus.req_size;
                            uns_q   <= bus.req_unsigned;
                            cnt     <= 4'(LATENCY - 1);
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_valid_r <= 1'b1;
                        state        <= RESP;
                        if (misaligned(size_q, off_q)) begin
                            misalign_r   <= 1'b1;
                            resp_rdata_r <= 64'd0;
                        end else if (write_q) begin
                            mem[idx_q]   <= merge(mem[idx_q], wdata_q, size_q, off_q);
                            resp_rdata_r <= 64'd0;
                        end else begin
                            resp_rdata_r <= extract(mem[idx_q], size_q, off_q, uns_q);
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // The request still visible here has already been serviced.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_resp   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit is_aligned(input logic [1:0] size, input logic [63:0] a);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return a[0] == 1'b0;
            2'b10:   return a[1:0] == 2'b00;
            default: return a[2:0] == 3'b000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.resp_valid) begin
            n_resp++;
            if (exp_q.size() == 0) check("resp_unexpected", bus.resp_valid, 1'b0);
            else check("resp_rdata", bus.resp_rdata, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Entered just after a rising edge; leaves just after the edge that ends RESP.
    task automatic access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input logic uns, input logic [63:0] exp,
                          input bit hold);
        int n;
        bit posted;
        posted = 1'b0;
`ifdef DMEM_POSTED_STORE_EN
        posted = wr && is_aligned(size, addr);
`endif
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        if (!posted) exp_q.push_back(wr ? 64'd0 : exp);
        n = 0;
        @(negedge clk);
        while (bus.stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (posted) check("posted_stall_cycles", n, 0);
        else        check("stall_cycles", n, LATENCY + 1);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    initial begin
        int resp_before;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = 64'd0;
        bus.req_wdata    = 64'd0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall",      bus.stall,        0);
        check("reset_resp_valid", bus.resp_valid,   0);
        check("reset_rdata",      bus.resp_rdata,   0);
        check("reset_misalign",   bus.misalign_err, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        access(1'b1, 64'h10, 64'h1122334455667788, 2'b11, 1'b0, 64'd0, 1'b0);
        access(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 64'h1122334455667788, 1'b0);
        access(1'b1, 64'h13, 64'h80, 2'b00, 1'b0, 64'd0, 1'b0);
        access(1'b0, 64'h13, 64'd0, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFF80, 1'b0);
        access(1'b0, 64'h13, 64'd0, 2'b00, 1'b1, 64'h0000000000000080, 1'b0);
        access(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 64'h1122334480667788, 1'b0);
        access(1'b0, 64'h12, 64'd0, 2'b01, 1'b0, 64'hFFFFFFFFFFFF8066, 1'b0);
        check("misalign_before", bus.misalign_err, 0);

        access(1'b0, 64'h21, 64'd0, 2'b01, 1'b0, 64'd0, 1'b0);
        check("misalign_set", bus.misalign_err, 1);
        access(1'b1, 64'h22, 64'hAAAAAAAA, 2'b10, 1'b0, 64'd0, 1'b0);
        access(1'b0, 64'h20, 64'd0, 2'b11, 1'b0, 64'd0, 1'b0);

        access(1'b1, 64'h200, 64'hDEADBEEF, 2'b10, 1'b0, 64'd0, 1'b0);
        access(1'b0, 64'h0, 64'd0, 2'b10, 1'b1, 64'h00000000DEADBEEF, 1'b0);
        access(1'b0, 64'h4, 64'd0, 2'b10, 1'b0, 64'd0, 1'b0);
        access(1'b0, 64'h200, 64'd0, 2'b10, 1'b0, 64'hFFFFFFFFDEADBEEF, 1'b0);
        check("misalign_sticky", bus.misalign_err, 1);

        resp_before = n_resp;
        access(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 64'h1122334480667788, 1'b1);
        access(1'b0, 64'h0, 64'd0, 2'b11, 1'b0, 64'h00000000DEADBEEF, 1'b0);
        check("held_valid_resp_count", n_resp - resp_before, 2);

        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'h8;
        bus.req_wdata = 64'h0123456789ABCDEF;
        bus.req_size  = 2'b11;
        @(posedge clk);
        #1;
        check("reset_mid_wait_stall", bus.stall, 1);
        reset = 1'b1;
        bus.req_valid = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_stall",      bus.stall,        0);
        check("midreset_resp_valid", bus.resp_valid,   0);
        check("midreset_rdata",      bus.resp_rdata,   0);
        check("midreset_misalign",   bus.misalign_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        access(1'b0, 64'h8, 64'd0, 2'b11, 1'b0, 64'd0, 1'b0);

`ifdef DMEM_POSTED_STORE_EN
        access(1'b1, 64'h8, 64'hCAFEF00D12345678, 2'b11, 1'b0, 64'd0, 1'b0);
        access(1'b0, 64'h8, 64'd0, 2'b11, 1'b0, 64'hCAFEF00D12345678, 1'b0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
